// File: rtl/debounce_pkg.sv
// Shared types and constants for the multi-channel push-button conditioner.
package debounce_pkg;

  // Per-channel press-tracking state.
  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    PRESSED  = 2'd1,
    HELD     = 2'd2
  } state_t;

  // Legal window for the debounce sample depth.
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 16;

  // Bits needed for a counter that must be able to hold max_val (never less than 1).
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: sample shift register, debounced level, press/release
// edge pulses, long-press detection and optional auto-repeat.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic slow_clk,
  input  logic button,
  input  logic repeat_en,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int HOLD_W = cnt_width(HOLD_TICKS);
  localparam int REP_W  = cnt_width(REPEAT_TICKS);

  // Counter value on the tick just before the threshold is reached.
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS - 1);

  logic [DEPTH-1:0]  shreg;
  logic [DEPTH-1:0]  shreg_nxt;
  logic              all_ones;
  logic              all_zeros;
  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;

  // The level decision looks at the shift register as it will be after this tick.
  assign shreg_nxt = {shreg[DEPTH-2:0], button};
  assign all_ones  = &shreg_nxt;
  assign all_zeros = ~|shreg_nxt;

  // Sampling, debounced level, FSM and counters; every output is registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg         <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      state         <= RELEASED;
      hold_cnt      <= '0;
      rep_cnt       <= '0;
    end else begin
      // Pulses default low so each lasts one clk even with slow_clk held high.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      if (slow_clk) begin
        shreg <= shreg_nxt;
        if (all_zeros && level) begin
          // Release wins from any state and clears both counters.
          level         <= 1'b0;
          release_pulse <= 1'b1;
          state         <= RELEASED;
          hold_cnt      <= '0;
          rep_cnt       <= '0;
        end else if (all_ones && !level) begin
          level       <= 1'b1;
          press_pulse <= 1'b1;
          state       <= PRESSED;
          hold_cnt    <= '0;
          rep_cnt     <= '0;
        end else begin
          case (state)
            PRESSED: begin
              if (hold_cnt == HOLD_LAST) begin
                // Counter parks at the threshold; HELD takes over from here.
                hold_cnt   <= HOLD_MAX;
                long_pulse <= 1'b1;
                state      <= HELD;
                rep_cnt    <= '0;
              end else begin
                hold_cnt <= hold_cnt + 1'b1;
              end
            end
            HELD: begin
              // Repeat timing keeps running when disabled; only the pulse is gated.
              if (rep_cnt == REP_LAST) begin
                rep_cnt     <= '0;
                press_pulse <= repeat_en;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button conditioner: parameter checks plus one
// debounce_channel per button, all sharing the clock and sample tick.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DEPTH        = 4,
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            slow_clk,
  input  logic [N_CH-1:0] button,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse
);

  // Reject illegal configurations at elaboration.
  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("debounce_multi: DEPTH out of range 2..16");
  end
  if (HOLD_TICKS < 1) begin : g_bad_hold
    $error("debounce_multi: HOLD_TICKS must be at least 1");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_repeat
    $error("debounce_multi: REPEAT_TICKS must be at least 1");
  end
  if (N_CH < 1) begin : g_bad_nch
    $error("debounce_multi: N_CH must be at least 1");
  end

  // Fully independent channels.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .DEPTH        (DEPTH),
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .slow_clk      (slow_clk),
      .button        (button[i]),
      .repeat_en     (repeat_en[i]),
      .level         (level_out[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .long_pulse    (long_pulse[i])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with DEPTH=4, HOLD_TICKS=5, REPEAT_TICKS=2.
module tb_debounce_multi;

  localparam int N_CH = 4;

  logic            clk;
  logic            rst_n;
  logic            slow_clk;
  logic [N_CH-1:0] button;
  logic [N_CH-1:0] repeat_en;
  logic [N_CH-1:0] level_out;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] long_pulse;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t sbq[$];

  debounce_multi #(
    .N_CH         (N_CH),
    .DEPTH        (4),
    .HOLD_TICKS   (5),
    .REPEAT_TICKS (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .slow_clk      (slow_clk),
    .button        (button),
    .repeat_en     (repeat_en),
    .level_out     (level_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive one clk of stimulus, queue the outputs expected after the next
  // posedge, then compare them at the following negedge.
  task automatic cyc(input string tag, input logic [3:0] btn, input logic tick,
                     input logic [3:0] ren, input logic rst,
                     input logic [3:0] lvl, input logic [3:0] pr,
                     input logic [3:0] rl, input logic [3:0] lg);
    exp_t        e;
    logic [15:0] obs;
    button    = btn;
    slow_clk  = tick;
    repeat_en = ren;
    rst_n     = ~rst;
    e.tag = tag;
    e.exp = {lvl, pr, rl, lg};
    sbq.push_back(e);
    @(negedge clk);
    e   = sbq.pop_front();
    obs = {level_out, press_pulse, release_pulse, long_pulse};
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s: observed lvl/pr/rl/lg=%h required %h", e.tag, obs, e.exp);
    end
  endtask

  // One sample tick followed by a quiet clk in which every pulse must be low.
  task automatic tk(input string tag, input logic [3:0] btn, input logic [3:0] ren,
                    input logic [3:0] lvl, input logic [3:0] pr,
                    input logic [3:0] rl, input logic [3:0] lg);
    cyc(tag, btn, 1'b1, ren, 1'b0, lvl, pr, rl, lg);
    cyc({tag, "_idle"}, btn, 1'b0, ren, 1'b0, lvl, 4'h0, 4'h0, 4'h0);
  endtask

  function automatic logic [3:0] sel(input bit c, input logic [3:0] v);
    return c ? v : 4'h0;
  endfunction

  initial begin
    logic [0:5] bseq;
    button    = '0;
    repeat_en = '0;
    slow_clk  = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);

    // Reset state
    cyc("reset0", 4'h0, 1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    cyc("reset1", 4'h0, 1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    cyc("post_reset", 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

    // Bounce 1,0,1,1,1,1: single press after the 6th tick
    bseq = 6'b101111;
    for (int i = 0; i < 6; i++)
      tk("bounce", {3'b000, bseq[i]}, 4'h0, sel(i == 5, 4'h1), sel(i == 5, 4'h1), 4'h0, 4'h0);
    for (int i = 1; i <= 4; i++)
      tk("bounce_rel", 4'h0, 4'h0, sel(i < 4, 4'h1), 4'h0, sel(i == 4, 4'h1), 4'h0);

    // Glitch of 3 ticks: nothing happens
    for (int i = 0; i < 3; i++) tk("glitch_hi", 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 4; i++) tk("glitch_lo", 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    // Long press, repeat disabled: press on tick 4, long 5 ticks later
    for (int i = 1; i <= 10; i++)
      tk("long_hold", 4'h1, 4'h0, sel(i >= 4, 4'h1), sel(i == 4, 4'h1), 4'h0, sel(i == 9, 4'h1));
    for (int i = 1; i <= 4; i++)
      tk("long_rel", 4'h0, 4'h0, sel(i < 4, 4'h1), 4'h0, sel(i == 4, 4'h1), 4'h0);

    // Auto-repeat: press at 4, long at 9, repeats at 11/13/15, then disabled
    for (int i = 1; i <= 15; i++)
      tk("repeat", 4'h1, 4'h1, sel(i >= 4, 4'h1),
         sel(i == 4 || i == 11 || i == 13 || i == 15, 4'h1), 4'h0, sel(i == 9, 4'h1));
    for (int i = 16; i <= 17; i++)
      tk("repeat_off", 4'h1, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0);

    // Reset while HELD: all outputs drop with no release pulse, then re-press
    cyc("rst_mid", 4'h1, 1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
    for (int i = 1; i <= 4; i++)
      tk("repress", 4'h1, 4'h0, sel(i == 4, 4'h1), sel(i == 4, 4'h1), 4'h0, 4'h0);
    for (int i = 1; i <= 4; i++)
      tk("repress_rel", 4'h0, 4'h0, sel(i < 4, 4'h1), 4'h0, sel(i == 4, 4'h1), 4'h0);

    // slow_clk tied high, ch0 and ch2 together
    for (int i = 1; i <= 12; i++)
      cyc("multi", 4'b0101, 1'b1, 4'h0, 1'b0, sel(i >= 4, 4'b0101),
          sel(i == 4, 4'b0101), 4'h0, sel(i == 9, 4'b0101));
    for (int i = 1; i <= 4; i++)
      cyc("multi_rel", 4'h0, 1'b1, 4'h0, 1'b0, sel(i < 4, 4'b0101), 4'h0,
          sel(i == 4, 4'b0101), 4'h0);
    cyc("final_idle", 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
